// File: rtl/fsm_branch_jump_ctrl.sv
// Control FSM for JAL/JALR/B-type sequencing with busy/done handshake and trap detection.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module fsm_branch_jump_ctrl #(
  parameter int IALIGN = 32,
  parameter int CNT_W  = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [31:0]      i_insn,
  input  logic [31:0]      i_code,
  input  logic             i_start,
  input  logic             i_lu,
  input  logic             i_ls,
  input  logic             i_eq,
  input  logic [1:0]       i_target_lo,
  output logic             o_sel_pc_next,
  output logic             o_sel_pc_increment,
  output logic             o_sel_pc_jump,
  output logic             o_load_pc,
  output logic             o_load_regfile,
  output logic             o_load_rs1,
  output logic             o_load_rs2,
  output logic             o_load_imm,
  output logic             o_load_pc_alu,
  output logic             o_load_flags,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_trap_misaligned,
  output logic             o_trap_illegal,
`ifdef BRANCH_STATS_EN
  input  logic             i_stats_clr,
  output logic [CNT_W-1:0] o_jump_cnt,
  output logic [CNT_W-1:0] o_taken_cnt,
  output logic [CNT_W-1:0] o_not_taken_cnt,
`endif
  output logic [3:0]       o_state
);

  // Handshake: start is sampled only in IDLE; busy is high in every other state,
  // and done pulses for exactly one cycle before the return to IDLE.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_J = 4'd2,
    S_EXEC_B = 4'd3,
    S_FLAGS  = 4'd4,
    S_WB_J   = 4'd5,
    S_WB_B   = 4'd6,
    S_TRAP   = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] w_funct3;
  logic       w_is_branch;
  logic       w_is_jalr;
  logic       w_misaligned;
  logic       w_taken;
  logic       w_inc_jump;
  logic       w_inc_taken;
  logic       w_inc_not_taken;
  logic       w_unused;

  assign w_funct3     = i_insn[14:12];
  assign w_is_branch  = i_code[24];
  assign w_is_jalr    = i_code[25];
  // Bit 0 of the target never matters: JALR clears it and branch offsets are even.
  assign w_misaligned = (IALIGN == 32) && i_target_lo[1];
  assign w_unused     = ^{i_insn[31:15], i_insn[11:0], i_code[31:26], i_code[23:0],
                          i_target_lo[0], w_inc_jump, w_inc_taken, w_inc_not_taken};
  assign o_state      = r_state;

  always_comb begin
    w_taken = 1'b0;
    case (w_funct3)
      3'b000:  w_taken = i_eq;
      3'b001:  w_taken = ~i_eq;
      3'b100:  w_taken = i_ls;
      3'b101:  w_taken = ~i_ls;
      3'b110:  w_taken = i_lu;
      3'b111:  w_taken = ~i_lu;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state       = S_IDLE;
    o_sel_pc_next      = 1'b0;
    o_sel_pc_increment = 1'b0;
    o_sel_pc_jump      = 1'b0;
    o_load_pc          = 1'b0;
    o_load_regfile     = 1'b0;
    o_load_rs1         = 1'b0;
    o_load_rs2         = 1'b0;
    o_load_imm         = 1'b0;
    o_load_pc_alu      = 1'b0;
    o_load_flags       = 1'b0;
    o_busy             = 1'b0;
    o_done             = 1'b0;
    o_trap_misaligned  = 1'b0;
    o_trap_illegal     = 1'b0;
    w_inc_jump         = 1'b0;
    w_inc_taken        = 1'b0;
    w_inc_not_taken    = 1'b0;
    // Reset forces every output low even while the state register still holds a busy state.
    if (!i_reset) begin
      o_busy = (r_state != S_IDLE);
      case (r_state)
        S_IDLE:   w_next_state = i_start ? S_DECODE : S_IDLE;
        S_DECODE: begin
          o_load_rs1 = 1'b1;
          o_load_rs2 = 1'b1;
          o_load_imm = 1'b1;
          if (!w_is_branch)              w_next_state = S_EXEC_J;
          else if (w_funct3[2:1] == 2'b01) w_next_state = S_TRAP;
          else                           w_next_state = S_EXEC_B;
        end
        S_EXEC_J: begin
          o_load_pc_alu = 1'b1;
          w_next_state  = S_WB_J;
        end
        S_EXEC_B: begin
          o_load_flags = 1'b1;
          w_next_state = S_FLAGS;
        end
        S_FLAGS:  w_next_state = S_WB_B;
        S_WB_J: begin
          o_sel_pc_next = 1'b1;
          o_sel_pc_jump = ~w_is_jalr;
          if (w_misaligned) begin
            o_trap_misaligned = 1'b1;
          end else begin
            o_load_pc      = 1'b1;
            o_load_regfile = 1'b1;
            w_inc_jump     = 1'b1;
          end
          w_next_state = S_DONE;
        end
        S_WB_B: begin
          if (!w_taken) begin
            o_load_pc       = 1'b1;
            w_inc_not_taken = 1'b1;
          end else if (w_misaligned) begin
            o_trap_misaligned = 1'b1;
          end else begin
            o_load_pc          = 1'b1;
            o_sel_pc_increment = 1'b1;
            w_inc_taken        = 1'b1;
          end
          w_next_state = S_DONE;
        end
        S_TRAP: begin
          o_trap_illegal = 1'b1;
          w_next_state   = S_DONE;
        end
        S_DONE: begin
          o_done       = 1'b1;
          w_next_state = S_IDLE;
        end
        default:  w_next_state = S_IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_jump_cnt;
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_not_taken_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_stats_clr) begin
      r_jump_cnt      <= '0;
      r_taken_cnt     <= '0;
      r_not_taken_cnt <= '0;
    end else begin
      if (w_inc_jump)      r_jump_cnt      <= r_jump_cnt + 1'b1;
      if (w_inc_taken)     r_taken_cnt     <= r_taken_cnt + 1'b1;
      if (w_inc_not_taken) r_not_taken_cnt <= r_not_taken_cnt + 1'b1;
    end
  end

  assign o_jump_cnt      = r_jump_cnt;
  assign o_taken_cnt     = r_taken_cnt;
  assign o_not_taken_cnt = r_not_taken_cnt;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_fsm_branch_jump_ctrl.sv
// Bench for fsm_branch_jump_ctrl: per-cycle output sequences from a transaction-level model.
// Statistics tests are compiled in when BRANCH_STATS_EN is defined.
module tb_fsm_branch_jump_ctrl;
  localparam int TB_CNT_W = 4;

  localparam logic [13:0] M_NEXT  = 14'h2000;
  localparam logic [13:0] M_INC   = 14'h1000;
  localparam logic [13:0] M_JUMP  = 14'h0800;
  localparam logic [13:0] M_LPC   = 14'h0400;
  localparam logic [13:0] M_LRF   = 14'h0200;
  localparam logic [13:0] M_RS1   = 14'h0100;
  localparam logic [13:0] M_RS2   = 14'h0080;
  localparam logic [13:0] M_IMM   = 14'h0040;
  localparam logic [13:0] M_PCALU = 14'h0020;
  localparam logic [13:0] M_FLAGS = 14'h0010;
  localparam logic [13:0] M_BUSY  = 14'h0008;
  localparam logic [13:0] M_DONE  = 14'h0004;
  localparam logic [13:0] M_TMIS  = 14'h0002;
  localparam logic [13:0] M_TILL  = 14'h0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] insn, code;
  logic        start, lu, ls, eq, stats_clr;
  logic [1:0]  target_lo;
  logic sel_pc_next, sel_pc_increment, sel_pc_jump, load_pc, load_regfile;
  logic load_rs1, load_rs2, load_imm, load_pc_alu, load_flags, busy, done;
  logic trap_misaligned, trap_illegal;
  logic [3:0] state_dbg;
  logic [TB_CNT_W-1:0] jump_cnt, taken_cnt, not_taken_cnt;

  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];
  logic [TB_CNT_W-1:0] m_jump, m_taken, m_ntaken;
  int checks = 0;
  int errors = 0;

  wire [13:0] obs_vec = {sel_pc_next, sel_pc_increment, sel_pc_jump, load_pc, load_regfile,
                         load_rs1, load_rs2, load_imm, load_pc_alu, load_flags, busy, done,
                         trap_misaligned, trap_illegal};

  fsm_branch_jump_ctrl #(.IALIGN(32), .CNT_W(TB_CNT_W)) dut (
    .i_clk(clk), .i_reset(reset), .i_insn(insn), .i_code(code), .i_start(start),
    .i_lu(lu), .i_ls(ls), .i_eq(eq), .i_target_lo(target_lo),
    .o_sel_pc_next(sel_pc_next), .o_sel_pc_increment(sel_pc_increment),
    .o_sel_pc_jump(sel_pc_jump), .o_load_pc(load_pc), .o_load_regfile(load_regfile),
    .o_load_rs1(load_rs1), .o_load_rs2(load_rs2), .o_load_imm(load_imm),
    .o_load_pc_alu(load_pc_alu), .o_load_flags(load_flags), .o_busy(busy), .o_done(done),
    .o_trap_misaligned(trap_misaligned), .o_trap_illegal(trap_illegal),
`ifdef BRANCH_STATS_EN
    .i_stats_clr(stats_clr), .o_jump_cnt(jump_cnt), .o_taken_cnt(taken_cnt),
    .o_not_taken_cnt(not_taken_cnt),
`endif
    .o_state(state_dbg)
  );

`ifndef BRANCH_STATS_EN
  assign jump_cnt = '0;
  assign taken_cnt = '0;
  assign not_taken_cnt = '0;
`endif

  always #5 clk = ~clk;

  // Reference: expected output vector for every cycle from the start edge onwards,
  // ending with one idle cycle; also advances the expected statistics.
  task automatic model_push(input logic [2:0] f3, input logic br, input logic jalr,
                            input logic e, input logic s, input logic u, input logic [1:0] tlo);
    logic [13:0] wb;
    logic taken;
    exp_q.push_back(M_BUSY | M_RS1 | M_RS2 | M_IMM);
    if (!br) begin
      exp_q.push_back(M_BUSY | M_PCALU);
      wb = M_BUSY | M_NEXT | (jalr ? 14'h0 : M_JUMP);
      if (tlo[1]) wb = wb | M_TMIS;
      else begin wb = wb | M_LPC | M_LRF; m_jump = m_jump + 1'b1; end
      exp_q.push_back(wb);
    end else if (f3 == 3'd2 || f3 == 3'd3) begin
      exp_q.push_back(M_BUSY | M_TILL);
    end else begin
      exp_q.push_back(M_BUSY | M_FLAGS);
      exp_q.push_back(M_BUSY);
      case (f3)
        3'd0: taken = e;
        3'd1: taken = !e;
        3'd4: taken = s;
        3'd5: taken = !s;
        3'd6: taken = u;
        default: taken = !u;
      endcase
      if (!taken) begin wb = M_BUSY | M_LPC; m_ntaken = m_ntaken + 1'b1; end
      else if (tlo[1]) wb = M_BUSY | M_TMIS;
      else begin wb = M_BUSY | M_LPC | M_INC; m_taken = m_taken + 1'b1; end
      exp_q.push_back(wb);
    end
    exp_q.push_back(M_BUSY | M_DONE);
    exp_q.push_back(14'h0);
  endtask

  // Driver: issues one instruction and records exp_q.size() samples, one per cycle.
  task automatic run_insn(input logic [2:0] f3, input logic br, input logic jalr,
                          input logic e, input logic s, input logic u, input logic [1:0] tlo,
                          input int poke, input bit hold, input int clr);
    int n;
    n = exp_q.size();
    obs_q.delete();
    insn = $urandom; insn[14:12] = f3;
    code = $urandom; code[24] = br; code[25] = jalr;
    eq = e; ls = s; lu = u; target_lo = tlo;
    start = 1'b1; stats_clr = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      obs_q.push_back(obs_vec);
      start = hold || (k == poke);
      stats_clr = (k == clr);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (obs_vec !== 14'h0) begin errors++; $display("FAIL reset_during got %b exp %b", obs_vec, 14'h0); end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs_vec !== 14'h0) begin errors++; $display("FAIL reset_after got %b exp %b", obs_vec, 14'h0); end
`ifdef BRANCH_STATS_EN
    checks++;
    if ({jump_cnt, taken_cnt, not_taken_cnt} !== 12'h0) begin
      errors++; $display("FAIL reset_cnt got %h exp 000", {jump_cnt, taken_cnt, not_taken_cnt});
    end
`endif
  endtask

  task automatic test_jump;
    logic [2:0] tab [3];
    tab[0] = 3'b000; tab[1] = 3'b101; tab[2] = 3'b110;  // {jalr, target_lo}
    for (int t = 0; t < 3; t++) begin
      exp_q.delete();
      model_push(3'($urandom), 1'b0, tab[t][2], 1'b0, 1'b0, 1'b0, tab[t][1:0]);
      run_insn(insn[14:12], 1'b0, tab[t][2], 1'b0, 1'b0, 1'b0, tab[t][1:0], 0, 1'b0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL jump case%0d cyc%0d got %b exp %b", t, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_branch;
    logic [7:0] tab [3];
    tab[0] = 8'b001_1_0_0_00; tab[1] = 8'b110_0_0_1_00; tab[2] = 8'b110_0_0_1_10;  // f3,eq,ls,lu,tlo
    for (int t = 0; t < 3; t++) begin
      exp_q.delete();
      model_push(tab[t][7:5], 1'b1, 1'b0, tab[t][4], tab[t][3], tab[t][2], tab[t][1:0]);
      run_insn(tab[t][7:5], 1'b1, 1'b0, tab[t][4], tab[t][3], tab[t][2], tab[t][1:0], 0, 1'b0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL branch case%0d cyc%0d got %b exp %b", t, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_illegal;
    for (int t = 2; t <= 3; t++) begin
      exp_q.delete();
      model_push(3'(t), 1'b1, 1'($urandom), 1'b1, 1'b1, 1'b1, 2'($urandom));
      run_insn(3'(t), 1'b1, code[25], 1'b1, 1'b1, 1'b1, 2'($urandom), 0, 1'b0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL illegal f3=%0d cyc%0d got %b exp %b", t, i + 1, obs_q[i], exp_q[i]);
        end
        checks++;
        if ((obs_q[i] & M_FLAGS) !== 14'h0) begin
          errors++; $display("FAIL illegal_flags cyc%0d got %b exp 0", i + 1, obs_q[i]);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [2:0] f3;
    logic br, jalr, e, s, u;
    logic [1:0] tlo;
    for (int t = 0; t < 40; t++) begin
      f3 = 3'($urandom); br = 1'($urandom); jalr = 1'($urandom);
      e = 1'($urandom); s = 1'($urandom); u = 1'($urandom); tlo = 2'($urandom_range(0, 3));
      exp_q.delete();
      model_push(f3, br, jalr, e, s, u, tlo);
      run_insn(f3, br, jalr, e, s, u, tlo, 0, 1'b0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL random t%0d cyc%0d got %b exp %b", t, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_busy_start;
    for (int p = 1; p <= 4; p++) begin
      exp_q.delete();
      model_push(3'b100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
      run_insn(3'b100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, p, 1'b0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL busy_start poke%0d cyc%0d got %b exp %b", p, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int t = 0; t < 2; t++) begin
      exp_q.delete();
      model_push(3'b000, 1'b0, 1'(t), 1'b0, 1'b0, 1'b0, 2'b00);
      run_insn(3'b000, 1'b0, 1'(t), 1'b0, 1'b0, 1'b0, 2'b00, 0, (t == 0), 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL back_to_back t%0d cyc%0d got %b exp %b", t, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    insn = 32'h0; code = 32'h0100_0000; eq = 1'b1; ls = 1'b0; lu = 1'b0; target_lo = 2'b00;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (obs_vec !== M_BUSY) begin errors++; $display("FAIL reset_mid_flags got %b exp %b", obs_vec, M_BUSY); end
    reset = 1'b1; #1;
    checks++;
    if (obs_vec !== 14'h0) begin errors++; $display("FAIL reset_mid_during got %b exp %b", obs_vec, 14'h0); end
    @(posedge clk); #1; reset = 1'b0; #1;
    checks++;
    if (obs_vec !== 14'h0) begin errors++; $display("FAIL reset_mid_next got %b exp %b", obs_vec, 14'h0); end
    @(posedge clk); #1;
    checks++;
    if (obs_vec !== 14'h0) begin errors++; $display("FAIL reset_mid_idle got %b exp %b", obs_vec, 14'h0); end
    m_jump = '0; m_taken = '0; m_ntaken = '0;
`ifdef BRANCH_STATS_EN
    checks++;
    if ({jump_cnt, taken_cnt, not_taken_cnt} !== 12'h0) begin
      errors++; $display("FAIL reset_mid_cnt got %h exp 000", {jump_cnt, taken_cnt, not_taken_cnt});
    end
`endif
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats;
    stats_clr = 1'b1;
    @(posedge clk); #1; stats_clr = 1'b0;
    m_jump = '0; m_taken = '0; m_ntaken = '0;
    for (int t = 0; t < 6; t++) begin
      exp_q.delete();
      if (t < 3) begin
        model_push(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        run_insn(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 0, 1'b0, 0);
      end else if (t < 5) begin
        model_push(3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
        run_insn(3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 0, 1'b0, 0);
      end else begin
        model_push(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
        run_insn(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 0, 1'b0, 0);
      end
    end
    checks++;
    if ({jump_cnt, taken_cnt, not_taken_cnt} !== {m_jump, m_taken, m_ntaken} || m_taken !== 4'd3) begin
      errors++; $display("FAIL stats_mix got %h exp %h", {jump_cnt, taken_cnt, not_taken_cnt}, 12'h132);
    end
    exp_q.delete();
    model_push(3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
    run_insn(3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 0, 1'b0, 4);
    m_jump = '0; m_taken = '0; m_ntaken = '0;
    checks++;
    if ({jump_cnt, taken_cnt, not_taken_cnt} !== 12'h000) begin
      errors++; $display("FAIL stats_clr_wins got %h exp 000", {jump_cnt, taken_cnt, not_taken_cnt});
    end
    for (int t = 0; t < 16; t++) begin
      exp_q.delete();
      model_push(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
      run_insn(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 1'b0, 0);
      if (t == 14) begin
        checks++;
        if (jump_cnt !== m_jump) begin errors++; $display("FAIL stats_15 got %0d exp %0d", jump_cnt, m_jump); end
      end
    end
    checks++;
    if (jump_cnt !== 4'd0 || m_jump !== 4'd0) begin
      errors++; $display("FAIL stats_wrap got %0d exp 0", jump_cnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; stats_clr = 1'b0; insn = '0; code = '0;
    lu = 1'b0; ls = 1'b0; eq = 1'b0; target_lo = 2'b00;
    m_jump = '0; m_taken = '0; m_ntaken = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_jump();
    test_branch();
    test_illegal();
    test_random();
    test_busy_start();
    test_back_to_back();
`ifdef BRANCH_STATS_EN
    checks++;
    if ({jump_cnt, taken_cnt, not_taken_cnt} !== {m_jump, m_taken, m_ntaken}) begin
      errors++; $display("FAIL stats_random got %h exp %h", {jump_cnt, taken_cnt, not_taken_cnt},
                         {m_jump, m_taken, m_ntaken});
    end
`endif
    test_reset_mid();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_branch_jump_ctrl.md
Name: fsm_branch_jump_ctrl

Overview:
- Parametrised next-generation control FSM for jump and branch instructions in the RV64 Control Unit.
- Sequences JAL, JALR and B-type instructions through the DataFlow ALU, in the same way as the existing branch/jump FSM.
- Adds a synchronous reset, a busy/done handshake, illegal-branch detection and instruction-address-misaligned detection with configurable IALIGN.
- Sits beside the other Control Unit FSMs; the opdecoder drives code and start.

Parameters:
- IALIGN, 32, instruction alignment in bits. 32 means the target must have bit 1 clear. 16 means no misalignment is possible (C extension).
- CNT_W, 32, width of the statistics counters (used only with the optional feature).

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high.
- insn, input, 32, current instruction; funct3 = insn[14:12].
- code, input, 32, opdecoder one-hot code. code[24]=1 means branch, otherwise jump. code[25]=1 means JALR, 0 means JAL.
- start, input, 1, leave IDLE; sampled only in IDLE.
- lu, ls, eq, input, 1 each, comparison flags from the flags register.
- target_lo, input, 2, bits [1:0] of the computed target (ALU output); valid in the WRITEBACK states.
- sel_pc_next, sel_pc_increment, sel_pc_jump, output, 1 each, PC and ALU-A selectors.
- load_pc, load_regfile, load_rs1, load_rs2, load_imm, load_pc_alu, load_flags, output, 1 each, register loads.
- busy, output, 1, high whenever state is not IDLE.
- done, output, 1, one-cycle pulse in DONE.
- trap_misaligned, output, 1, one-cycle pulse.
- trap_illegal, output, 1, one-cycle pulse.

Behaviour:
- Reset has priority over everything. On reset: state goes to IDLE; every output is 0; counters are 0.
- A reset asserted mid-instruction aborts it. No load is asserted in the cycle after reset.
- All outputs are combinational from state plus inputs. Default value of every output is 0.
- States (4-bit): IDLE, DECODE, EXEC_J, EXEC_B, FLAGS, WB_J, WB_B, TRAP, DONE.
- Transitions:
  - IDLE goes to DECODE if start, else stays in IDLE.
  - DECODE: if code[24]=0, go to EXEC_J. If code[24]=1 and funct3 is 010 or 011, go to TRAP. Otherwise go to EXEC_B.
  - EXEC_J goes to WB_J.
  - EXEC_B goes to FLAGS, then FLAGS goes to WB_B.
  - WB_J, WB_B and TRAP go to DONE.
  - DONE goes to IDLE.
  - Any unused encoding goes to IDLE.
- Outputs per state:
  - DECODE: load_rs1, load_rs2 and load_imm are 1.
  - EXEC_J: load_pc_alu=1.
  - EXEC_B: load_flags=1.
  - FLAGS: all outputs 0 (flags settle).
  - WB_J: sel_pc_jump = ~code[25]; sel_pc_next=1.
  - WB_B: taken is eq, ~eq, ls, ~ls, lu, ~lu for funct3 000, 001, 100, 101, 110, 111 respectively.
  - TRAP: trap_illegal=1.
  - DONE: done=1.
- Misalignment check: misaligned = (IALIGN==32) && target_lo[1]. For JALR, target bit 0 is ignored.
- WB_J when not misaligned: load_pc=1 and load_regfile=1.
- WB_J when misaligned: load_pc=0, load_regfile=0, trap_misaligned=1.
- WB_B when taken and not misaligned: load_pc=1, sel_pc_increment=1.
- WB_B when not taken: load_pc=1, sel_pc_increment=0 (PC+4). Misalignment is ignored.
- WB_B when taken and misaligned: load_pc=0, trap_misaligned=1.
- Latency, counted from the edge that samples start=1:
  - done at cycle 4 for a jump;
  - done at cycle 5 for a branch;
  - done at cycle 3 for an illegal branch.
- Handshake: start is ignored while busy. start held high through DONE retriggers only after returning to IDLE, giving a one-cycle IDLE gap.
- The trap pulses and done are never high in the same cycle.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, adds:
  - input stats_clr (1);
  - outputs jump_cnt, taken_cnt, not_taken_cnt (CNT_W each).
- Counter updates:
  - jump_cnt increments in WB_J when there is no trap.
  - taken_cnt increments in WB_B when taken and there is no trap.
  - not_taken_cnt increments in WB_B when not taken.
- Counters wrap modulo 2^CNT_W.
- Precedence: reset beats stats_clr, and stats_clr beats any increment in the same cycle.
- When not defined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- JAL (code[24]=0, code[25]=0, target_lo=00), start pulse:
  - DECODE loads at cycle 1, load_pc_alu at cycle 2;
  - WB_J at cycle 3 with load_pc=1, load_regfile=1, sel_pc_jump=1, sel_pc_next=1;
  - done at cycle 4; busy high for cycles 1-4.
- JALR, target_lo=01, IALIGN=32: WB_J has sel_pc_jump=0 and load_pc=1, with no trap.
- JALR, target_lo=10: WB_J has trap_misaligned=1, load_pc=0, load_regfile=0; done follows.
- BNE (funct3=001), eq=1: WB_B at cycle 4 with load_pc=1, sel_pc_increment=0.
- BLTU, lu=1, target_lo=00: sel_pc_increment=1; done at cycle 5.
- BLTU, lu=1, target_lo=10: trap_misaligned=1.
- funct3=010 branch: TRAP at cycle 2 with trap_illegal=1, and load_flags never asserted.
- Reset asserted in FLAGS: next cycle is IDLE with all outputs 0 and busy=0.
- A start pulse during busy is ignored.
- With BRANCH_STATS_EN: run 3 taken, 2 not-taken and 1 jump, giving counts 3, 2, 1.
- With BRANCH_STATS_EN: stats_clr coincident with a taken WB_B gives taken_cnt=0.
- With BRANCH_STATS_EN and CNT_W=4: 16 jumps wrap jump_cnt to 0.
